dmem_access_ctrl: RTL and testbench
===================================

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: cycles allowed in REQ+WAIT before abort (used only with DMEM_TIMEOUT_EN).
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 valid_in  input  1  stage instruction valid.
REQ-005 inst  input  32  stage instruction; opcode, funct3 decoded.
REQ-006 addr  input  32  effective address (ALU output).
REQ-007 wdata  input  32  store data (rs2).
REQ-008 mem_req  output  1  memory request, held until mem_gnt.
REQ-009 mem_we  output  1  1=store, 0=load.
REQ-010 mem_addr  output  32  {addr[31:2],2'b00}.
REQ-011 mem_be  output  4  byte-lane enables.
REQ-012 mem_wdata  output  32  wdata shifted left by 8*addr[1:0].
REQ-013 mem_gnt  input  1  request accepted.
REQ-014 mem_rvalid  input  1  load data valid.
REQ-015 mem_rdata  input  32  load data.
REQ-016 raw_dmem  output  32  registered load word for load-select mux.
REQ-017 stall  output  1  freeze upstream pipeline.
REQ-018 misaligned  output  1  one-cycle misaligned-access pulse.
REQ-019 timeout  output  1  one-cycle abort pulse; tied 0 without DMEM_TIMEOUT_EN.

Function
REQ-020 FSM states IDLE, REQ, WAIT, DONE.
REQ-021 Memory op = valid_in and opcode 0000011 (load) or 0100011 (store); all else ignored, FSM stays IDLE.
REQ-022 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0 -> misaligned=1 that cycle, no request, stall=0, stay IDLE.
REQ-023 IDLE + aligned op -> REQ next edge; stall=1 combinationally from that IDLE cycle.
REQ-024 REQ: mem_req=1, address/be/wdata/we stable until mem_gnt sampled high.
REQ-025 REQ+gnt, store -> DONE; load -> WAIT; load with gnt and rvalid same cycle -> capture, DONE.
REQ-026 WAIT: on mem_rvalid capture mem_rdata into raw_dmem, -> DONE.
REQ-027 DONE: stall=0, mem_req=0, -> IDLE next edge; one-cycle completion, no re-issue.
REQ-028 stall=1 in REQ and WAIT; 0 in DONE and idle-without-op.
REQ-029 mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; same for loads.
REQ-030 mem_rvalid outside WAIT/REQ-load and mem_gnt outside REQ ignored.
REQ-031 raw_dmem holds value until next load capture.

Reset
REQ-032 reset -> IDLE, mem_req=0, mem_we=0, mem_be=0, raw_dmem=0, stall=0, misaligned=0, timeout=0, counter=0.
REQ-033 Reset mid-access abandons it; late gnt/rvalid after reset ignored.

Configuration
REQ-034 Macro DMEM_TIMEOUT_EN: counter increments each REQ/WAIT cycle, clears in IDLE; reaching TIMEOUT_CYCLES drops mem_req, pulses timeout, leaves raw_dmem=0, -> DONE.
REQ-035 Without DMEM_TIMEOUT_EN: no counter; REQ/WAIT wait indefinitely; timeout constant 0.

Structure
REQ-036 Shared package: load/store opcodes, funct3 width codes, FSM state enum, byte-enable widths.
REQ-037 Sub-module dmem_lane_gen: combinational be/wdata shift and misalignment check.

Verification
REQ-038 sw addr=0x100 wdata=0xDEADBEEF, gnt after 2 cycles -> be=1111, addr=0x100, stall 3 cycles, DONE.
REQ-039 sb addr=0x103 wdata=0x000000AB -> be=1000, mem_wdata=0xAB000000.
REQ-040 lw addr=0x200, gnt cycle 1, rvalid cycle 3 rdata=0x12345678 -> raw_dmem=0x12345678, stall deasserts in DONE.
REQ-041 lh addr=0x201 -> misaligned=1 one cycle, mem_req never asserted, stall=0.
REQ-042 Reset asserted in WAIT, then rvalid=1 -> IDLE, raw_dmem=0, no capture.
REQ-043 DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, gnt never -> timeout pulse after 8 REQ cycles, mem_req drops.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
// Holds the load/store opcodes, the funct3 access-size codes, the
// byte-enable patterns and the controller FSM state type.
package dmem_access_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3[1:0] access size; funct3[2] (unsigned load) does not affect lanes
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int BE_W = 4;
  localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
  localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } dmem_state_e;

  // True for the two opcodes that touch data memory
  function automatic logic is_mem_opcode(input logic [6:0] opcode);
    return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory request/response bus.
//   master (controller): drives mem_req, mem_we, mem_addr, mem_be, mem_wdata;
//                        receives mem_gnt, mem_rvalid, mem_rdata.
//   slave  (memory)    : the mirror image.
interface dmem_access_ctrl_if;
  import dmem_access_ctrl_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [BE_W-1:0] mem_be;
  logic [31:0]     mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [31:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/dmem_lane_gen.sv
// Byte-lane generator: from access size and address offset produce the
// byte enables, the lane-aligned store data and the misalignment flag.
// Purely combinational.
//   size       : funct3[1:0] access size
//   offset     : addr[1:0]
//   wdata      : unshifted store data
//   be         : byte-lane enables
//   wdata_sh   : wdata shifted left by 8*offset
//   misaligned : access crosses its natural alignment
module dmem_lane_gen
  import dmem_access_ctrl_pkg::*;
(
  input  logic [1:0]      size,
  input  logic [1:0]      offset,
  input  logic [31:0]     wdata,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wdata_sh,
  output logic            misaligned
);

  assign wdata_sh = wdata << {offset, 3'b000};

  // Lane enables and alignment check per access size
  always_comb begin
    be         = BE_WORD;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        be         = BE_BYTE << offset;
        misaligned = 1'b0;
      end
      SIZE_HALF: begin
        be         = BE_HALF << offset;
        misaligned = offset[0];
      end
      // word, and the unused size code treated as word
      default: begin
        be         = BE_WORD;
        misaligned = |offset;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the MEM pipeline stage.
// Decodes load/store instructions, issues one request on the memory bus,
// waits for grant and (for loads) read data, captures the load word and
// stalls the upstream pipeline while the access is in flight.
// Optional feature macro: DMEM_TIMEOUT_EN -- aborts an access that spends
// TIMEOUT_CYCLES cycles in REQ+WAIT and pulses 'timeout'.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   valid_in     : stage instruction valid
//   inst         : instruction (opcode, funct3 decoded)
//   addr, wdata  : effective address, store data
//   bus          : memory bus (master side)
//   raw_dmem     : last captured load word
//   stall        : freeze upstream pipeline
//   misaligned   : misaligned-access pulse
//   timeout      : abort pulse (constant 0 without DMEM_TIMEOUT_EN)
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
)
(
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic [31:0]         inst,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  dmem_access_ctrl_if.master  bus,
  output logic [31:0]         raw_dmem,
  output logic                stall,
  output logic                misaligned,
  output logic                timeout
);

  dmem_state_e     state_r;
  logic [6:0]      opcode_s;
  logic [1:0]      size_s;
  logic            is_store_s;
  logic            mem_op_s;
  logic [BE_W-1:0] lane_be_s;
  logic [31:0]     lane_wdata_s;
  logic            lane_mis_s;
  logic            start_s;
  logic            timeout_fire_s;
  logic            unused_s;

  assign opcode_s   = inst[6:0];
  assign size_s     = inst[13:12];
  assign is_store_s = (opcode_s == OPC_STORE);
  assign mem_op_s   = valid_in & is_mem_opcode(opcode_s);
  assign unused_s   = ^{inst[31:14], inst[11:7]};

  dmem_lane_gen u_lane_gen (
    .size       (size_s),
    .offset     (addr[1:0]),
    .wdata      (wdata),
    .be         (lane_be_s),
    .wdata_sh   (lane_wdata_s),
    .misaligned (lane_mis_s)
  );

  // Only IDLE looks at the instruction; later states own the access.
  assign start_s    = (state_r == ST_IDLE) & mem_op_s & ~lane_mis_s;
  assign misaligned = (state_r == ST_IDLE) & mem_op_s & lane_mis_s;
  // Stall is raised in the same IDLE cycle the access is accepted so the
  // upstream stage does not advance past it.
  assign stall      = start_s | (state_r == ST_REQ) | (state_r == ST_WAIT);

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_r;
  logic             timeout_r;

  // Fires on the last allowed cycle unless that cycle completes the phase.
  assign timeout_fire_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) &
                          (((state_r == ST_REQ)  & ~bus.mem_gnt) |
                           ((state_r == ST_WAIT) & ~bus.mem_rvalid));

  // Busy-cycle counter and registered abort pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= '0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= timeout_fire_s;
      if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign timeout = timeout_r;
`else
  logic unused_cfg_s;

  assign unused_cfg_s   = (TIMEOUT_CYCLES > 0);
  assign timeout_fire_s = 1'b0;
  assign timeout        = 1'b0;
`endif

  // Access FSM with registered bus outputs and load-data capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'h0000_0000;
      bus.mem_be    <= 4'b0000;
      bus.mem_wdata <= 32'h0000_0000;
      raw_dmem      <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r       <= ST_REQ;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= is_store_s;
            bus.mem_addr  <= {addr[31:2], 2'b00};
            bus.mem_be    <= lane_be_s;
            bus.mem_wdata <= lane_wdata_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            if (bus.mem_we) begin
              state_r <= ST_DONE;
            end else if (bus.mem_rvalid) begin
              // zero-latency memory: data arrives with the grant
              raw_dmem <= bus.mem_rdata;
              state_r  <= ST_DONE;
            end else begin
              state_r <= ST_WAIT;
            end
          end else if (timeout_fire_s) begin
            bus.mem_req <= 1'b0;
            raw_dmem    <= 32'h0000_0000;
            state_r     <= ST_DONE;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (bus.mem_rvalid) begin
            raw_dmem <= bus.mem_rdata;
            state_r  <= ST_DONE;
          end else if (timeout_fire_s) begin
            raw_dmem <= 32'h0000_0000;
            state_r  <= ST_DONE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed, scoreboard-based bench for dmem_access_ctrl.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] inst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] raw_dmem;
  logic        stall;
  logic        misaligned;
  logic        timeout;

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .inst       (inst),
    .addr       (addr),
    .wdata      (wdata),
    .bus        (bus.master),
    .raw_dmem   (raw_dmem),
    .stall      (stall),
    .misaligned (misaligned),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] raw_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, op};
  endfunction

  // Runs one access. Called at posedge+1 of an IDLE cycle (cycle 0).
  // gnt/rvalid are driven during the given cycle numbers (-1 = never).
  task automatic access(input string name, input logic [31:0] i_inst,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic e_we, input logic [31:0] e_addr,
                        input logic [3:0] e_be, input logic [31:0] e_wd,
                        input int gnt_cyc, input int rv_cyc, input logic [31:0] rd,
                        input logic [31:0] e_raw, input int e_stall, input int e_to);
    int   cyc;
    int   stall_n;
    int   to_n;
    bit   done;
    req_t exp_r;
    req_q.push_back('{we: e_we, addr: e_addr, be: e_be, wdata: e_wd});
    raw_q.push_back(e_raw);
    valid_in = 1'b1; inst = i_inst; addr = a; wdata = wd;
    cyc = 0; stall_n = 0; to_n = 0; done = 1'b0;
    exp_r = '{we: 1'b0, addr: 32'h0, be: 4'h0, wdata: 32'h0};
    while (!done && cyc < 40) begin
      bus.mem_gnt    = (cyc == gnt_cyc);
      bus.mem_rvalid = (cyc == rv_cyc);
      bus.mem_rdata  = (cyc == rv_cyc) ? rd : 32'h5A5A_5A5A;
      #4;
      if (timeout) to_n++;
      if (stall) stall_n++;
      if (cyc == 0) begin
        chk({name, "_stall_idle"}, {31'd0, stall}, 32'd1);
        chk({name, "_req_idle"}, {31'd0, bus.mem_req}, 32'd0);
      end else if (stall) begin
        if (cyc == 1) begin
          chk({name, "_req"}, {31'd0, bus.mem_req}, 32'd1);
          if (req_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd0, 32'd1);
          end else begin
            exp_r = req_q.pop_front();
          end
          chk({name, "_we"}, {31'd0, bus.mem_we}, {31'd0, exp_r.we});
          chk({name, "_wdata"}, bus.mem_wdata, exp_r.wdata);
        end
        if (bus.mem_req) begin
          chk({name, "_addr"}, bus.mem_addr, exp_r.addr);
          chk({name, "_be"}, {28'd0, bus.mem_be}, {28'd0, exp_r.be});
        end
      end else begin
        done = 1'b1;
        chk({name, "_req_done"}, {31'd0, bus.mem_req}, 32'd0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    valid_in = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    chk({name, "_completed"}, {31'd0, done}, 32'd1);
    chk({name, "_stall_cycles"}, stall_n, e_stall);
    chk({name, "_timeout_pulses"}, to_n, e_to);
    #4;
    chk({name, "_no_reissue"}, {31'd0, bus.mem_req}, 32'd0);
    chk({name, "_raw_dmem"}, raw_dmem, raw_q.pop_front());
    @(posedge clk); #1;
  endtask

  // One instruction held for a single cycle that must not start an access.
  task automatic no_access(input string name, input logic [31:0] i_inst,
                           input logic [31:0] a, input logic e_mis);
    valid_in = 1'b1; inst = i_inst; addr = a; wdata = 32'hFFFF_FFFF;
    #4;
    chk({name, "_mis"}, {31'd0, misaligned}, {31'd0, e_mis});
    chk({name, "_stall"}, {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    #4;
    chk({name, "_mis_gone"}, {31'd0, misaligned}, 32'd0);
    chk({name, "_no_req"}, {31'd0, bus.mem_req}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; inst = 32'h0; addr = 32'h0; wdata = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_be", {28'd0, bus.mem_be}, 32'd0);
    chk("rst_raw", raw_dmem, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // sw: grant in second REQ cycle, stray rvalid during REQ ignored
    access("sw", mk_inst(OP_ST, 3'b010), 32'h0000_0100, 32'hDEAD_BEEF,
           1'b1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 2, 1, 32'hFFFF_0000,
           32'h0, 3, 0);
    access("sb", mk_inst(OP_ST, 3'b000), 32'h0000_0103, 32'h0000_00AB,
           1'b1, 32'h0000_0100, 4'b1000, 32'hAB00_0000, 1, -1, 32'h0,
           32'h0, 2, 0);
    access("sh", mk_inst(OP_ST, 3'b001), 32'h0000_0102, 32'h0000_BEEF,
           1'b1, 32'h0000_0100, 4'b1100, 32'hBEEF_0000, 1, -1, 32'h0,
           32'h0, 2, 0);
    access("lw", mk_inst(OP_LD, 3'b010), 32'h0000_0200, 32'h0,
           1'b0, 32'h0000_0200, 4'b1111, 32'h0, 1, 3, 32'h1234_5678,
           32'h1234_5678, 4, 0);
    access("lb", mk_inst(OP_LD, 3'b000), 32'h0000_0402, 32'h0,
           1'b0, 32'h0000_0400, 4'b0100, 32'h0, 1, 1, 32'hCAFE_F00D,
           32'hCAFE_F00D, 2, 0);

    no_access("lh_mis", mk_inst(OP_LD, 3'b001), 32'h0000_0201, 1'b1);
    no_access("sw_mis", mk_inst(OP_ST, 3'b010), 32'h0000_0106, 1'b1);
    no_access("alu", mk_inst(OP_ALU, 3'b010), 32'h0000_0200, 1'b0);
    chk("raw_hold", raw_dmem, 32'hCAFE_F00D);

`ifdef DMEM_TIMEOUT_EN
    access("to_sw", mk_inst(OP_ST, 3'b010), 32'h0000_0500, 32'h0000_0001,
           1'b1, 32'h0000_0500, 4'b1111, 32'h0000_0001, -1, -1, 32'h0,
           32'h0, 9, 1);
`endif

    // Reset while waiting for load data; late rvalid must be ignored
    valid_in = 1'b1; inst = mk_inst(OP_LD, 3'b010); addr = 32'h0000_0300;
    #4;
    chk("rw_stall0", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    bus.mem_gnt = 1'b1;
    #4;
    chk("rw_req", {31'd0, bus.mem_req}, 32'd1);
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0; valid_in = 1'b0;
    #4;
    chk("rw_wait_stall", {31'd0, stall}, 32'd1);
    chk("rw_wait_req", {31'd0, bus.mem_req}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rw_rst_stall", {31'd0, stall}, 32'd0);
    chk("rw_rst_raw", raw_dmem, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h9999_9999;
    #4;
    chk("rw_late_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    #4;
    chk("rw_no_capture", raw_dmem, 32'd0);
    chk("rw_idle_req", {31'd0, bus.mem_req}, 32'd0);
    @(posedge clk); #1;

    // Recovery after reset: grant and data in the same REQ cycle
    access("lw2", mk_inst(OP_LD, 3'b010), 32'h0000_0600, 32'h0,
           1'b0, 32'h0000_0600, 4'b1111, 32'h0, 2, 2, 32'h0BAD_F00D,
           32'h0BAD_F00D, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
